vend_control_fsm: RTL and testbench

- Vending-machine transaction controller; sits directly upstream of the 4-digit display driver.
- Produces the 3-bit display state code, the accumulated credit `val_tot` (in R$0.25 units) and the latched product ID (`row`/`col`) that the display driver consumes.
- Consumes decoded keypad, confirm/cancel and coin-acceptor pulses, and drives dispense/change/reject pulses to the mechanism.

---
 rtl/vend_control_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_vend_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_control_fsm.sv
// ---------------------------------------------------------------------------
// vend_control_fsm
//
// Transaction controller for the vending machine. It tracks product
// selection, coin credit and the result display. It feeds the 4-digit display
// driver (state code, credit, product ID) and pulses the dispense/change/reject
// mechanism.
//
// Parameters
//   HOLD_CYCLES    : clocks a result state (success / invalid ID / invalid
//                    value) stays on the display before returning to wait
//   TIMEOUT_CYCLES : idle clocks tolerated in the coin state before an
//                    automatic cancel with refund
//   AVAIL_MASK     : bit {row,col} set means that product slot is stocked
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   key_valid, key_row, key_col: keypad key pulse and its position
//   confirm, cancel            : user confirm / abort pulses
//   coin_25, coin_50, coin_100 : coin acceptor pulses (1, 2, 4 units)
//   state                      : display code (000 wait ... 101 invalid value)
//   val_tot                    : credit in R$0.25 units, 0..8
//   row, col                   : latched product ID
//   dispense                   : one-cycle product release pulse
//   change_val, change_pulse   : change amount, valid during the pulse
//   coin_reject                : one-cycle pulse returning the current coin
// ---------------------------------------------------------------------------
module vend_control_fsm #(
    parameter int          HOLD_CYCLES    = 50_000_000,
    parameter int          TIMEOUT_CYCLES = 500_000_000,
    parameter logic [15:0] AVAIL_MASK     = 16'h7FFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [1:0] key_row,
    input  logic [1:0] key_col,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       coin_25,
    input  logic       coin_50,
    input  logic       coin_100,
    output logic [2:0] state,
    output logic [3:0] val_tot,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       dispense,
    output logic [3:0] change_val,
    output logic       change_pulse,
    output logic       coin_reject
);

    // Counter widths follow the parameters; the guard keeps a 1-bit counter
    // legal when a parameter is 1.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    // The encodings are the display codes, so the state register drives the
    // display port directly.
    typedef enum logic [2:0] {
        ST_WAIT    = 3'b000,
        ST_ID      = 3'b001,
        ST_COIN    = 3'b010,
        ST_SUCCESS = 3'b011,
        ST_INV_ID  = 3'b100,
        ST_INV_VAL = 3'b101
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      val_d, change_d;
    logic [1:0]      row_d, col_d;
    logic            dispense_d, change_pulse_d, reject_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   tmr_q, tmr_d;

    logic [3:0]      coin_units;
    logic            coin_any;
    logic [4:0]      sum;
    logic [3:0]      price;
    logic            key_ok;

    assign state = state_q;

    // Only one coin is accepted per cycle: the most valuable one wins.
    // sum is one bit wider so overflow past 8 units is visible.
    always_comb begin
        coin_units = 4'd0;
        if (coin_100)
            coin_units = 4'd4;
        else if (coin_50)
            coin_units = 4'd2;
        else if (coin_25)
            coin_units = 4'd1;
        coin_any = coin_25 | coin_50 | coin_100;
        sum      = {1'b0, val_tot} + {1'b0, coin_units};
        key_ok   = AVAIL_MASK[{key_row, key_col}];
    end

    // Price depends only on the latched row: 2, 4, 6 or 8 units.
    always_comb begin
        price = 4'd2;
        case (row)
            2'd0: price = 4'd2;
            2'd1: price = 4'd4;
            2'd2: price = 4'd6;
            2'd3: price = 4'd8;
            default: price = 4'd2;
        endcase
    end

    // Next-state and next-output logic. Pulses default low so each one lasts
    // a single cycle. Both timers default to zero, so they restart whenever
    // their state is entered.
    always_comb begin
        state_d        = state_q;
        val_d          = val_tot;
        row_d          = row;
        col_d          = col;
        dispense_d     = 1'b0;
        change_d       = 4'd0;
        change_pulse_d = 1'b0;
        reject_d       = 1'b0;
        hold_d         = '0;
        tmr_d          = '0;

        case (state_q)
            ST_WAIT: begin
                if (key_valid) begin
                    row_d   = key_row;
                    col_d   = key_col;
                    state_d = key_ok ? ST_ID : ST_INV_ID;
                end
            end

            ST_ID: begin
                if (cancel) begin
                    state_d = ST_WAIT;
                end else if (key_valid) begin
                    row_d   = key_row;
                    col_d   = key_col;
                    state_d = key_ok ? ST_ID : ST_INV_ID;
                end else if (confirm) begin
                    val_d   = 4'd0;
                    state_d = ST_COIN;
                end
            end

            ST_COIN: begin
                if (cancel) begin
                    reject_d       = coin_any;
                    change_d       = val_tot;
                    change_pulse_d = (val_tot != 4'd0);
                    val_d          = 4'd0;
                    state_d        = ST_WAIT;
                end else if (coin_any) begin
                    if (sum > 5'd8) begin
                        reject_d       = 1'b1;
                        change_d       = val_tot;
                        change_pulse_d = (val_tot != 4'd0);
                        state_d        = ST_INV_VAL;
                    end else if (sum >= {1'b0, price}) begin
                        val_d          = sum[3:0];
                        dispense_d     = 1'b1;
                        change_d       = sum[3:0] - price;
                        change_pulse_d = (sum[3:0] != price);
                        state_d        = ST_SUCCESS;
                    end else begin
                        val_d = sum[3:0];
                    end
                end else if (key_valid) begin
                    tmr_d = '0;
                end else if (tmr_q == TMO_LAST) begin
                    change_d       = val_tot;
                    change_pulse_d = (val_tot != 4'd0);
                    val_d          = 4'd0;
                    state_d        = ST_WAIT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_SUCCESS, ST_INV_ID, ST_INV_VAL: begin
                if (hold_q == HOLD_LAST) begin
                    val_d   = 4'd0;
                    state_d = ST_WAIT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                val_d   = 4'd0;
                state_d = ST_WAIT;
            end
        endcase
    end

    // State and registered outputs. Reset drops any transaction in progress
    // without a refund.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT;
            val_tot      <= 4'd0;
            row          <= 2'd0;
            col          <= 2'd0;
            dispense     <= 1'b0;
            change_val   <= 4'd0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            hold_q       <= '0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            val_tot      <= val_d;
            row          <= row_d;
            col          <= col_d;
            dispense     <= dispense_d;
            change_val   <= change_d;
            change_pulse <= change_pulse_d;
            coin_reject  <= reject_d;
            hold_q       <= hold_d;
            tmr_q        <= tmr_d;
        end
    end

endmodule

// File: tb/tb_vend_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_vend_control_fsm
//
// Self-checking bench for vend_control_fsm with short hold and timeout
// values. A transaction-level reference model runs alongside the DUT and is
// stepped once per clock. Directed scenarios and a randomized pulse stream
// are compared against it after every edge.
// ---------------------------------------------------------------------------
module tb_vend_control_fsm;

    localparam int          HOLD = 4;
    localparam int          TMO  = 20;
    localparam logic [15:0] MASK = 16'h7FFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid, confirm, cancel, coin_25, coin_50, coin_100;
    logic [1:0] key_row, key_col;
    logic [2:0] state;
    logic [3:0] val_tot, change_val;
    logic [1:0] row, col;
    logic       dispense, change_pulse, coin_reject;

    int compared   = 0;
    int mismatched = 0;

    // The reference model works in display codes, credit units and counts of
    // remaining hold clocks and elapsed idle clocks.
    int m_mode, m_credit, m_row, m_col, m_hold_left, m_idle, m_change;
    bit m_disp, m_cpulse, m_reject;

    vend_control_fsm #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO),
        .AVAIL_MASK    (MASK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_row     (key_row),
        .key_col     (key_col),
        .confirm     (confirm),
        .cancel      (cancel),
        .coin_25     (coin_25),
        .coin_50     (coin_50),
        .coin_100    (coin_100),
        .state       (state),
        .val_tot     (val_tot),
        .row         (row),
        .col         (col),
        .dispense    (dispense),
        .change_val  (change_val),
        .change_pulse(change_pulse),
        .coin_reject (coin_reject)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Backstop so a broken design can never hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit stocked(input int r, input int c);
        logic [15:0] m;
        m = MASK;
        return m[r * 4 + c];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_credit = 0; m_row = 0; m_col = 0;
        m_hold_left = 0; m_idle = 0; m_change = 0;
        m_disp = 0; m_cpulse = 0; m_reject = 0;
    endtask

    task automatic model_select(input int kr, input int kc);
        m_row = kr;
        m_col = kc;
        if (stocked(kr, kc)) begin
            m_mode = 1;
        end else begin
            m_mode = 4;
            m_hold_left = HOLD;
        end
    endtask

    task automatic model_refund();
        m_change = m_credit;
        m_cpulse = (m_credit > 0);
    endtask

    // One clock of the transaction rules.
    task automatic model_step(input bit kv, input int kr, input int kc, input bit cf,
                              input bit cn, input bit c25, input bit c50, input bit c100);
        int coin, n;
        m_disp = 0; m_cpulse = 0; m_reject = 0; m_change = 0;
        coin = c100 ? 4 : (c50 ? 2 : (c25 ? 1 : 0));
        case (m_mode)
            0: if (kv) model_select(kr, kc);
            1: begin
                if (cn) m_mode = 0;
                else if (kv) model_select(kr, kc);
                else if (cf) begin m_mode = 2; m_credit = 0; m_idle = 0; end
            end
            2: begin
                if (cn) begin
                    m_reject = (coin > 0);
                    model_refund();
                    m_credit = 0;
                    m_mode = 0;
                end else if (coin > 0) begin
                    m_idle = 0;
                    n = m_credit + coin;
                    if (n > 8) begin
                        m_reject = 1;
                        model_refund();
                        m_mode = 5;
                        m_hold_left = HOLD;
                    end else if (n >= 2 * (m_row + 1)) begin
                        m_credit = n;
                        m_disp = 1;
                        m_change = n - 2 * (m_row + 1);
                        m_cpulse = (m_change > 0);
                        m_mode = 3;
                        m_hold_left = HOLD;
                    end else begin
                        m_credit = n;
                    end
                end else if (kv) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        model_refund();
                        m_credit = 0;
                        m_mode = 0;
                    end
                end
            end
            default: begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    m_mode = 0;
                    m_credit = 0;
                end
            end
        endcase
    endtask

    // Compare every visible output against the model.
    task automatic check_output();
        check("state", 8'(state), 8'(m_mode));
        check("val_tot", 8'(val_tot), 8'(m_credit));
        check("row", 8'(row), 8'(m_row));
        check("col", 8'(col), 8'(m_col));
        check("dispense", 8'(dispense), 8'(m_disp));
        check("change_pulse", 8'(change_pulse), 8'(m_cpulse));
        check("coin_reject", 8'(coin_reject), 8'(m_reject));
        if (m_cpulse) check("change_val", 8'(change_val), 8'(m_change));
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare.
    task automatic apply_stimulus(input bit kv, input int kr, input int kc, input bit cf,
                                  input bit cn, input bit c25, input bit c50, input bit c100);
        key_valid = kv; key_row = 2'(kr); key_col = 2'(kc);
        confirm = cf; cancel = cn;
        coin_25 = c25; coin_50 = c50; coin_100 = c100;
        model_step(kv, kr, kc, cf, cn, c25, c50, c100);
        @(posedge clk);
        #1;
        key_valid = 0; confirm = 0; cancel = 0;
        coin_25 = 0; coin_50 = 0; coin_100 = 0;
        check_output();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic press_key(input int r, input int c);
        apply_stimulus(1, r, c, 0, 0, 0, 0, 0);
    endtask

    task automatic press_confirm();
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic insert(input int units);
        apply_stimulus(0, 0, 0, 0, 0, units == 1, units == 2, units == 4);
    endtask

    initial begin
        rst_n = 0;
        key_valid = 0; key_row = 0; key_col = 0;
        confirm = 0; cancel = 0; coin_25 = 0; coin_50 = 0; coin_100 = 0;
        model_reset();
        #12;
        $display("[TB] reset state");
        check_output();
        check("reset_change_val", 8'(change_val), 8'd0);
        @(negedge clk);
        rst_n = 1;

        $display("[TB] reselect in ID");
        press_key(1, 2);
        press_key(0, 1);
        check("reselect_row", 8'(row), 8'd0);
        check("reselect_col", 8'(col), 8'd1);
        press_confirm();
        insert(2);
        check("reselect_dispense", 8'(dispense), 8'd1);
        idle_cycles(4);

        $display("[TB] exact pay");
        press_key(1, 1);
        press_confirm();
        insert(4);
        check("exact_val", 8'(val_tot), 8'd4);
        idle_cycles(4);

        $display("[TB] overpay with change");
        press_key(0, 0);
        press_confirm();
        insert(1);
        insert(4);
        check("overpay_change", 8'(change_val), 8'd3);
        idle_cycles(4);

        $display("[TB] invalid ID");
        press_key(3, 3);
        check("inv_id_state", 8'(state), 8'd4);
        press_confirm();
        idle_cycles(4);

        $display("[TB] overflow");
        press_key(3, 0);
        press_confirm();
        insert(4);
        insert(2);
        insert(4);
        check("overflow_change", 8'(change_val), 8'd6);
        check("overflow_state", 8'(state), 8'd5);
        idle_cycles(4);

        $display("[TB] timeout");
        press_key(2, 0);
        press_confirm();
        insert(2);
        idle_cycles(19);
        check("timeout_not_yet", 8'(state), 8'd2);
        idle_cycles(1);
        check("timeout_change", 8'(change_val), 8'd2);
        idle_cycles(1);

        $display("[TB] cancel with coin");
        press_key(2, 0);
        press_confirm();
        insert(1);
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 0);
        check("cancel_reject", 8'(coin_reject), 8'd1);

        $display("[TB] reset mid-transaction");
        press_key(1, 3);
        press_confirm();
        insert(2);
        rst_n = 0;
        #2;
        model_reset();
        check_output();
        check("midreset_val", 8'(val_tot), 8'd0);
        @(negedge clk);
        rst_n = 1;
        idle_cycles(1);

        $display("[TB] randomized pulses");
        for (int i = 0; i < 800; i++) begin
            bit kv, cf, cn, c25, c50, c100;
            int kr, kc;
            kv   = ($urandom_range(0, 5) == 0);
            kr   = $urandom_range(0, 3);
            kc   = $urandom_range(0, 3);
            cf   = !kv && ($urandom_range(0, 3) == 0);
            cn   = ($urandom_range(0, 24) == 0);
            c25  = ($urandom_range(0, 5) == 0);
            c50  = ($urandom_range(0, 5) == 0);
            c100 = ($urandom_range(0, 6) == 0);
            apply_stimulus(kv, kr, kc, cf, cn, c25, c50, c100);
            if (i % 200 == 199) idle_cycles(22);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
